shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Command-driven controller for the 4-bit universal shift register (MODO/DIR/S_IN/D/Q/S_OUT interface).
//  Accepts {op, data, count, fill bit} over a valid/ready handshake, parallel-loads the register,
//  issues exactly <count> shift or rotate steps, then returns the final Q with a one-cycle done pulse.
//  Sits between a command source and the register; the register is never driven directly by requesters.
// PARAMETERS
//  WIDTH  4  register width; widths of sr_d, sr_q, cmd_data and result
//  CNT_W  3  width of cmd_count; maximum of 2**CNT_W-1 steps per command
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  ENB        in   1      synchronous active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      controller idle, command accepted when valid&&ready at posedge
//  cmd_op     in   2      00 shift-left, 01 shift-right, 10 rotate-left, 11 rotate-right
//  cmd_data   in   WIDTH  word parallel-loaded before stepping
//  cmd_count  in   CNT_W  number of shift/rotate steps (0 = load only)
//  cmd_sin    in   1      serial fill bit for shift ops (ignored for rotates)
//  sr_enb     out  1      to register ENB (0 clears register)
//  sr_modo    out  2      to register MODO: 00 shift, 01 rotate, 10 parallel load, 11 hold
//  sr_dir     out  1      to register DIR: 0 left, 1 right
//  sr_sin     out  1      to register S_IN
//  sr_d       out  WIDTH  to register D
//  sr_q       in   WIDTH  from register Q
//  sr_sout    in   1      from register S_OUT
//  busy       out  1      command in progress (= !cmd_ready)
//  done       out  1      one-cycle pulse; result valid in the same cycle
//  result     out  WIDTH  sr_q sampled in DONE; held until next done
//  cap_data   out  WIDTH  serial-out capture (see CONFIGURATION)
// BEHAVIOUR
//  - ENB=0 at a posedge: state IDLE; sr_enb=0, sr_modo=11, sr_dir=0, sr_sin=0, sr_d=0, done=0,
//    result=0, cap_data=0, cmd_ready=0. First posedge with ENB=1: sr_enb=1, cmd_ready=1.
//  - Reset mid-command aborts it: no done pulse, register cleared via sr_enb=0.
//  - All outputs registered. States: IDLE -> LOAD -> RUN -> DONE -> IDLE.
//  - IDLE: cmd_ready=1, sr_modo=11. valid&&ready at edge E0 latches op/data/count/sin -> LOAD.
//  - LOAD (1 cycle after E0): sr_modo=10, sr_d=data; register loads at E1.
//    count==0 -> DONE, else load down-counter with count -> RUN.
//  - RUN: sr_modo=00 (op[1]=0) or 01 (op[1]=1); sr_dir=op[0]; sr_sin=latched sin.
//    One step per cycle; counter decrements each edge; leaves RUN after exactly count steps.
//  - DONE: sr_modo=11, result<=sr_q, done=1 for one cycle; -> IDLE (cmd_ready=1 next cycle).
//  - Latency: done asserted count+2 cycles after the accept edge (load-only: 2 cycles).
//  - cmd_valid while busy ignored; no queuing. cmd_* may change freely after accept.
//  - count = 2**CNT_W-1 executes all steps (no wrap to 0). Rotate by WIDTH returns data unchanged.
// CONFIGURATION
//  SHIFT_SEQ_CAPTURE_EN defined: cap_data shifts in sr_sout at every RUN edge
//    (cap_data <= {cap_data[WIDTH-2:0], sr_sout}); cleared at accept; holds after DONE.
//  Not defined: cap_data tied to 0; port kept for bench uniformity.
// STRUCTURE
//  shift_seq_defs.vh: op codes, MODO codes (LOAD=10, SHIFT=00, ROTATE=01, HOLD=11), state encoding.
//  Sub-module shift_seq_cnt: loadable CNT_W down-counter with zero flag. Bench instantiates the real
//  shift register and connects sr_* to it.
// TESTING
//  1 ENB=0 for 2 cycles -> sr_enb=0, cmd_ready=0, result=0; release -> cmd_ready=1 next cycle.
//  2 op=00 data=0000 count=4 sin=1 -> done 6 cycles after accept, result=1111.
//  3 op=10 data=1010 count=1 -> result=0101; op=11 data=0001 count=1 -> result=1000.
//  4 op=01 data=1001 count=0 -> RUN skipped, done 2 cycles after accept, result=1001.
//  5 cmd_valid held high during busy -> second command accepted only in cycle after done.
//  6 ENB=0 during RUN of count=7 -> no done, state IDLE; with SHIFT_SEQ_CAPTURE_EN,
//    op=00 data=1011 count=4 -> cap_data=1011.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared op codes, register MODO codes and FSM state encoding for shift_sequencer.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_SHL = 2'b00,
    OP_SHR = 2'b01,
    OP_ROL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    MODO_SHIFT  = 2'b00,
    MODO_ROTATE = 2'b01,
    MODO_LOAD   = 2'b10,
    MODO_HOLD   = 2'b11
  } modo_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  // op[1] selects rotate vs shift; op[0] is the direction and goes to DIR.
  function automatic modo_e run_modo(input logic [1:0] op);
    return op[1] ? MODO_ROTATE : MODO_SHIFT;
  endfunction

endpackage

// File: rtl/shift_seq_cnt.sv
// Loadable down-counter holding the remaining step count; zero/last flags steer the FSM.
module shift_seq_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer for a 4-bit universal shift register: load, step <count> times, report Q.
// Optional serial-out capture is enabled by defining SHIFT_SEQ_CAPTURE_EN.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             ENB,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_sin,
  output logic             sr_enb,
  output logic [1:0]       sr_modo,
  output logic             sr_dir,
  output logic             sr_sin,
  output logic [WIDTH-1:0] sr_d,
  input  logic [WIDTH-1:0] sr_q,
  input  logic             sr_sout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] cap_data
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sin_q, sin_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             sr_enb_q, sr_enb_d;
  modo_e            sr_modo_q, sr_modo_d;
  logic             sr_dir_q, sr_dir_d;
  logic             sr_sin_q, sr_sin_d;
  logic [WIDTH-1:0] sr_d_q, sr_d_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept;
  logic             cnt_zero, cnt_last;
  logic [CNT_W-1:0] cnt_val;

  assign accept = cmd_valid && cmd_ready_q;

  // Count is loaded on the accept edge so LOAD can already see a zero request.
  shift_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (ENB),
    .load     (accept),
    .dec      (state_q == S_RUN),
    .load_val (cmd_count),
    .cnt      (cnt_val),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    sin_d   = sin_q;
    case (state_q)
      S_IDLE: if (accept) begin
        op_d    = cmd_op;
        data_d  = cmd_data;
        sin_d   = cmd_sin;
        state_d = S_LOAD;
      end
      S_LOAD:  state_d = cnt_zero ? S_DONE : S_RUN;
      S_RUN:   if (cnt_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Register-facing outputs are decoded from the next state so they are flops.
    cmd_ready_d = (state_d == S_IDLE);
    sr_enb_d    = 1'b1;
    sr_modo_d   = MODO_HOLD;
    sr_dir_d    = 1'b0;
    sr_sin_d    = 1'b0;
    sr_d_d      = '0;
    case (state_d)
      S_LOAD: begin
        sr_modo_d = MODO_LOAD;
        sr_d_d    = data_d;
      end
      S_RUN: begin
        sr_modo_d = run_modo(op_d);
        sr_dir_d  = op_d[0];
        sr_sin_d  = sin_d;
      end
      default: ;
    endcase

    // Q is final one cycle after the last step, i.e. while sitting in DONE.
    done_d   = (state_q == S_DONE);
    result_d = (state_q == S_DONE) ? sr_q : result_q;
  end

  always_ff @(posedge clk) begin
    if (!ENB) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      data_q      <= '0;
      sin_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      sr_enb_q    <= 1'b0;
      sr_modo_q   <= MODO_HOLD;
      sr_dir_q    <= 1'b0;
      sr_sin_q    <= 1'b0;
      sr_d_q      <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      sin_q       <= sin_d;
      cmd_ready_q <= cmd_ready_d;
      sr_enb_q    <= sr_enb_d;
      sr_modo_q   <= sr_modo_d;
      sr_dir_q    <= sr_dir_d;
      sr_sin_q    <= sr_sin_d;
      sr_d_q      <= sr_d_d;
      done_q      <= done_d;
      result_q    <= result_d;
    end
  end

`ifdef SHIFT_SEQ_CAPTURE_EN
  logic [WIDTH-1:0] cap_q, cap_d;

  always_comb begin
    cap_d = cap_q;
    if (accept)
      cap_d = '0;
    else if (state_q == S_RUN)
      cap_d = {cap_q[WIDTH-2:0], sr_sout};
  end

  always_ff @(posedge clk) begin
    if (!ENB) cap_q <= '0;
    else      cap_q <= cap_d;
  end

  assign cap_data = cap_q;
`else
  logic unused_sout;
  assign unused_sout = sr_sout;
  assign cap_data    = '0;
`endif

  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = cnt_val;

  assign cmd_ready = cmd_ready_q;
  assign busy      = ~cmd_ready_q;
  assign sr_enb    = sr_enb_q;
  assign sr_modo   = sr_modo_q;
  assign sr_dir    = sr_dir_q;
  assign sr_sin    = sr_sin_q;
  assign sr_d      = sr_d_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer driving a behavioural 4-bit universal shift register.
module tb_shift_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             ENB = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             cmd_sin = 1'b0;
  logic             sr_enb;
  logic [1:0]       sr_modo;
  logic             sr_dir;
  logic             sr_sin;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] sr_q;
  logic             sr_sout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] cap_data;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .ENB(ENB),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_sin(cmd_sin),
    .sr_enb(sr_enb), .sr_modo(sr_modo), .sr_dir(sr_dir), .sr_sin(sr_sin),
    .sr_d(sr_d), .sr_q(sr_q), .sr_sout(sr_sout),
    .busy(busy), .done(done), .result(result), .cap_data(cap_data)
  );

  // Universal shift register: MODO 00 shift, 01 rotate, 10 load, 11 hold; DIR 1 = right.
  logic [WIDTH-1:0] q_reg = '0;
  always @(posedge clk) begin
    if (!sr_enb) q_reg <= '0;
    else case (sr_modo)
      2'b00:   q_reg <= sr_dir ? {sr_sin, q_reg[WIDTH-1:1]} : {q_reg[WIDTH-2:0], sr_sin};
      2'b01:   q_reg <= sr_dir ? {q_reg[0], q_reg[WIDTH-1:1]} : {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
      2'b10:   q_reg <= sr_d;
      default: q_reg <= q_reg;
    endcase
  end
  assign sr_q    = q_reg;
  assign sr_sout = sr_dir ? q_reg[0] : q_reg[WIDTH-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               cyc;
    bit               chk_cap;
    logic [WIDTH-1:0] cap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

`ifdef SHIFT_SEQ_CAPTURE_EN
  localparam logic [WIDTH-1:0] CAP_EXP = 4'b1011;
`else
  localparam logic [WIDTH-1:0] CAP_EXP = 4'b0000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result %0h with no command outstanding (cycle %0d)", result, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result", 32'(result), 32'(mon_e.res));
        chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.chk_cap) chk("cap_data", 32'(cap_data), 32'(mon_e.cap));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] n,
                       input logic s, input logic [WIDTH-1:0] res, input bit expect_done,
                       input bit keep, input bit chk_cap, input logic [WIDTH-1:0] cap,
                       output int acc);
    int w;
    @(negedge clk);
    cmd_op = op; cmd_data = d; cmd_count = n; cmd_sin = s; cmd_valid = 1'b1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cmd_ready %b after %0d cycles, required 1", cmd_ready, w);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (expect_done) sb.push_back('{res, acc + int'(n) + 2, chk_cap, cap});
    @(negedge clk);
    chk("busy_after_accept", 32'(busy), 32'd1);
    if (!keep) cmd_valid = 1'b0;
    cmd_data = ~d;
    cmd_op   = ~op;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((sb.size() != 0 || cmd_ready !== 1'b1) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: %0d results outstanding, cmd_ready %b", sb.size(), cmd_ready);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int a, b, d0;
    ENB = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sr_enb", 32'(sr_enb), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sr_modo", 32'(sr_modo), 32'd3);
    chk("rst_cap", 32'(cap_data), 32'd0);
    ENB = 1'b1;
    @(negedge clk);
    chk("release_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("release_sr_enb", 32'(sr_enb), 32'd1);

    // op, data, count, sin, expected result
    issue(2'b00, 4'b0000, 3'd4, 1'b1, 4'b1111, 1, 0, 0, '0, a); wait_idle();
    issue(2'b10, 4'b1010, 3'd1, 1'b0, 4'b0101, 1, 0, 0, '0, a); wait_idle();
    issue(2'b11, 4'b0001, 3'd1, 1'b0, 4'b1000, 1, 0, 0, '0, a); wait_idle();
    issue(2'b01, 4'b1001, 3'd0, 1'b0, 4'b1001, 1, 0, 0, '0, a); wait_idle();
    issue(2'b10, 4'b0110, 3'd7, 1'b0, 4'b0011, 1, 0, 0, '0, a); wait_idle();
    issue(2'b11, 4'b1101, 3'd4, 1'b0, 4'b1101, 1, 0, 0, '0, a); wait_idle();
    issue(2'b01, 4'b1000, 3'd3, 1'b0, 4'b0001, 1, 0, 0, '0, a); wait_idle();
    issue(2'b01, 4'b1001, 3'd2, 1'b1, 4'b1110, 1, 0, 0, '0, a); wait_idle();

    // valid held through busy: second command taken on the edge closing the done cycle
    issue(2'b00, 4'b0011, 3'd2, 1'b0, 4'b1100, 1, 1, 0, '0, a);
    issue(2'b11, 4'b0110, 3'd1, 1'b0, 4'b0011, 1, 0, 0, '0, b);
    chk("held_valid_accept_cycle", 32'(b), 32'(a + 2 + 3));
    wait_idle();

    // reset in the middle of a long command aborts it silently
    issue(2'b00, 4'b1111, 3'd7, 1'b1, 4'b0000, 0, 0, 0, '0, a);
    repeat (2) @(negedge clk);
    d0 = done_seen;
    ENB = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_sr_enb", 32'(sr_enb), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("abort_sr_modo", 32'(sr_modo), 32'd3);
    ENB = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(done_seen - d0), 32'd0);
    chk("abort_reg_cleared", 32'(q_reg), 32'd0);
    chk("abort_idle_ready", 32'(cmd_ready), 32'd1);

    issue(2'b00, 4'b1011, 3'd4, 1'b0, 4'b0000, 1, 0, 1, CAP_EXP, a); wait_idle();
    repeat (3) @(negedge clk);
    chk("cap_holds_after_done", 32'(cap_data), 32'(CAP_EXP));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
